// File: rtl/phase_to_ftw_decoder.sv
// phase_to_ftw_decoder: recovers the NCO tuning word from a phase stream (optional min/max via FTW_MINMAX_EN)
module phase_to_ftw_decoder #(
  parameter int PHASE_W  = 32,
  parameter int LOG2_AVG = 4,
  parameter int LOCK_CNT = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PHASE_W-1:0] phase_in,
  input  logic               phase_valid_in,
  input  logic               clear_in,
  output logic [PHASE_W-1:0] delta_out,
  output logic               delta_valid_out,
  output logic [PHASE_W-1:0] ftw_out,
  output logic               ftw_valid_out,
`ifdef FTW_MINMAX_EN
  output logic [PHASE_W-1:0] delta_min_out,
  output logic [PHASE_W-1:0] delta_max_out,
`endif
  output logic               locked_out
);
  localparam int SUM_W = PHASE_W + LOG2_AVG;
  localparam int MC_W = $clog2(LOCK_CNT + 1);
  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] RUN = 1'b1;
  localparam logic [LOG2_AVG-1:0] WIN_LAST = '1;
  localparam logic [MC_W-1:0] LOCK_MAX = MC_W'(LOCK_CNT);
  logic [0:0]         state;
  logic [PHASE_W-1:0] prev_phase;
  logic [SUM_W-1:0]   sum;
  logic [LOG2_AVG-1:0] win_cnt;
  logic [MC_W-1:0]    match_cnt;
  logic               first_delta;
  logic [PHASE_W-1:0] delta;
  logic [SUM_W-1:0]   sum_nxt;
  logic [MC_W-1:0]    match_nxt;
  logic               take;
  logic               match;
  logic               win_close;
  // modular increment between consecutive valid samples and the lock/window bookkeeping it drives
  always_comb begin
    delta = phase_in - prev_phase;
    take = phase_valid_in && !clear_in && (state == RUN);
    match = !first_delta && (delta == delta_out);
    match_nxt = match ? ((match_cnt == LOCK_MAX) ? match_cnt : match_cnt + 1'b1) : '0;
    sum_nxt = sum + SUM_W'(delta);
    win_close = (win_cnt == WIN_LAST);
  end
  // measurement state machine: reference capture, delta output, window averaging and lock tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
      prev_phase <= '0;
      sum <= '0;
      win_cnt <= '0;
      match_cnt <= '0;
      first_delta <= 1'b0;
      delta_out <= '0;
      delta_valid_out <= 1'b0;
      ftw_out <= '0;
      ftw_valid_out <= 1'b0;
      locked_out <= 1'b0;
    end else begin
      delta_valid_out <= 1'b0;
      ftw_valid_out <= 1'b0;
      if (clear_in) begin
        state <= EMPTY;
        sum <= '0;
        win_cnt <= '0;
        match_cnt <= '0;
        locked_out <= 1'b0;
      end else if (phase_valid_in) begin
        prev_phase <= phase_in;
        if (state == EMPTY) begin
          state <= RUN;
          first_delta <= 1'b1;
        end else begin
          delta_out <= delta;
          delta_valid_out <= 1'b1;
          first_delta <= 1'b0;
          match_cnt <= match_nxt;
          locked_out <= (match_nxt == LOCK_MAX);
          if (win_close) begin
            ftw_out <= PHASE_W'(sum_nxt >> LOG2_AVG);
            ftw_valid_out <= 1'b1;
            sum <= '0;
            win_cnt <= '0;
          end else begin
            sum <= sum_nxt;
            win_cnt <= win_cnt + 1'b1;
          end
        end
      end
    end
  end
`ifdef FTW_MINMAX_EN
  logic [PHASE_W-1:0] run_min;
  logic [PHASE_W-1:0] run_max;
  logic [PHASE_W-1:0] min_nxt;
  logic [PHASE_W-1:0] max_nxt;
  // the window's first delta seeds the running extremes so a cleared partial window never leaks
  always_comb begin
    min_nxt = (win_cnt == '0) ? delta : ((delta < run_min) ? delta : run_min);
    max_nxt = (win_cnt == '0) ? delta : ((delta > run_max) ? delta : run_max);
  end
  // running extremes, published alongside the averaged tuning word
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_min <= '0;
      run_max <= '0;
      delta_min_out <= '0;
      delta_max_out <= '0;
    end else if (take) begin
      run_min <= min_nxt;
      run_max <= max_nxt;
      if (win_close) begin
        delta_min_out <= min_nxt;
        delta_max_out <= max_nxt;
      end
    end
  end
`endif
endmodule

// File: tb/tb_phase_to_ftw_decoder.sv
// tb_phase_to_ftw_decoder: scoreboard bench for phase_to_ftw_decoder
module tb_phase_to_ftw_decoder;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] phase_in = '0;
  logic        phase_valid_in = 1'b0;
  logic        clear_in = 1'b0;
  logic [31:0] delta_out;
  logic        delta_valid_out;
  logic [31:0] ftw_out;
  logic        ftw_valid_out;
  logic        locked_out;
`ifdef FTW_MINMAX_EN
  logic [31:0] delta_min_out;
  logic [31:0] delta_max_out;
`endif
  typedef struct { logic [31:0] d; logic l; } dexp_t;
  typedef struct { logic [31:0] f; logic [31:0] mn; logic [31:0] mx; } fexp_t;
  dexp_t dq[$];
  fexp_t fq[$];
  int checks = 0;
  int errors = 0;

  phase_to_ftw_decoder dut (
    .clk(clk),
    .rst(rst),
    .phase_in(phase_in),
    .phase_valid_in(phase_valid_in),
    .clear_in(clear_in),
    .delta_out(delta_out),
    .delta_valid_out(delta_valid_out),
    .ftw_out(ftw_out),
    .ftw_valid_out(ftw_valid_out),
`ifdef FTW_MINMAX_EN
    .delta_min_out(delta_min_out),
    .delta_max_out(delta_max_out),
`endif
    .locked_out(locked_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // monitor: pops the scoreboard whenever the DUT presents a result
  always @(negedge clk) begin
    if (delta_valid_out) begin
      if (dq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL delta_unexpected actual=%h expected=none", delta_out);
      end else begin
        dexp_t e;
        e = dq.pop_front();
        chk("delta", delta_out, e.d);
        chk("locked", {31'd0, locked_out}, {31'd0, e.l});
      end
    end
    if (ftw_valid_out) begin
      if (fq.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL ftw_unexpected actual=%h expected=none", ftw_out);
      end else begin
        fexp_t e;
        e = fq.pop_front();
        chk("ftw", ftw_out, e.f);
`ifdef FTW_MINMAX_EN
        chk("delta_min", delta_min_out, e.mn);
        chk("delta_max", delta_max_out, e.mx);
`endif
      end
    end
  end

  task automatic drive(input logic v, input logic [31:0] p, input logic c);
    phase_valid_in = v;
    phase_in = p;
    clear_in = c;
    @(posedge clk);
    #1;
    phase_valid_in = 1'b0;
    clear_in = 1'b0;
  endtask

  task automatic ramp(input logic [31:0] start, input logic [31:0] step, input int n, input int gap);
    logic [31:0] p;
    p = start;
    for (int k = 1; k <= n; k++) begin
      if (k >= 2) dq.push_back('{step, k >= 10});
      if (k >= 17 && (k - 1) % 16 == 0) fq.push_back('{step, step, step});
      drive(1'b1, p, 1'b0);
      for (int g = 0; g < gap; g++) drive(1'b0, 32'd0, 1'b0);
      p = p + step;
    end
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_delta"}, delta_out, 32'd0);
    chk({tag, "_dvalid"}, {31'd0, delta_valid_out}, 32'd0);
    chk({tag, "_ftw"}, ftw_out, 32'd0);
    chk({tag, "_fvalid"}, {31'd0, ftw_valid_out}, 32'd0);
    chk({tag, "_locked"}, {31'd0, locked_out}, 32'd0);
`ifdef FTW_MINMAX_EN
    chk({tag, "_min"}, delta_min_out, 32'd0);
    chk({tag, "_max"}, delta_max_out, 32'd0);
`endif
  endtask

  initial begin
    logic [31:0] p;
    logic [31:0] d;
    #2;
    check_zero("reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    ramp(32'd0, 32'd100, 18, 0);
    drive(1'b0, 32'd0, 1'b1);
    ramp(32'hFFFF_FD00, 32'h200, 17, 0);
    drive(1'b0, 32'd0, 1'b1);
    p = 32'd1000;
    drive(1'b1, p, 1'b0);
    for (int i = 1; i <= 32; i++) begin
      d = (i % 2 == 1) ? 32'd99 : 32'd101;
      p = p + d;
      dq.push_back('{d, 1'b0});
      if (i % 16 == 0) fq.push_back('{32'd100, 32'd99, 32'd101});
      drive(1'b1, p, 1'b0);
    end
    drive(1'b0, 32'd0, 1'b1);
    ramp(32'd7, 32'd50, 6, 0);
    drive(1'b1, 32'd9999, 1'b1);
    ramp(32'd5000, 32'd70, 17, 0);
    drive(1'b0, 32'd0, 1'b1);
    ramp(32'd0, 32'd100, 18, 2);
    drive(1'b0, 32'd0, 1'b1);
    ramp(32'd123, 32'd30, 8, 0);
    drive(1'b0, 32'd0, 1'b0);
    #3;
    rst = 1'b1;
    #1;
    check_zero("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    ramp(32'd400, 32'd40, 17, 0);
    repeat (4) drive(1'b0, 32'd0, 1'b0);
    chk("delta_queue_drained", dq.size(), 32'd0);
    chk("ftw_queue_drained", fq.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
